// File: rtl/delay_trigger_ctrl.sv
// delay_trigger_ctrl: trigger-window capture controller for a delayed trace stream.
// After a warm-up that fills the external delay line, a trigger (with enable)
// captures one window of DELAY_CYCLES+1+POST_CYCLES consecutive samples from
// sr_dout into a small output FIFO. A hold-off follows each window.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   enable, trigger   trigger acceptance arm and trigger request
//   sr_dout           delayed sample from the shift register
//   out_data/out_last FIFO head sample and last-of-window flag
//   out_valid         FIFO non-empty; out_ready consumer accept
//   busy              controller not idle or FIFO non-empty
//   overflow_cnt      saturating count of dropped samples

`ifndef DBG_TIMESTAMP_WIDTH
`define DBG_TIMESTAMP_WIDTH 32
`endif
`ifndef DBG_TRIGGER_DELAY
`define DBG_TRIGGER_DELAY 8
`endif

module delay_trigger_ctrl #(
  parameter int unsigned DATA_WIDTH     = `DBG_TIMESTAMP_WIDTH + 32 + 16,
  parameter int unsigned DELAY_CYCLES   = `DBG_TRIGGER_DELAY,
  parameter int unsigned POST_CYCLES    = 16,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned HOLDOFF_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  trigger,
  input  logic [DATA_WIDTH-1:0] sr_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [7:0]            overflow_cnt
);

  localparam int unsigned WIN_LEN = DELAY_CYCLES + 1 + POST_CYCLES;
  localparam int unsigned CNT_W   = $clog2(WIN_LEN + DELAY_CYCLES + HOLDOFF_CYCLES + 2);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    IDLE    = 2'd1,
    CAPTURE = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              push_req;
  logic              push_last;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr, rd_next;
  logic [FCNT_W-1:0]     count, count_next, count_after_pop;
  logic                  pop, full, push_acc, drop;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= WARMUP;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and sample push request; cnt is the sample index in a window
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    push_req   = 1'b0;
    push_last  = 1'b0;
    case (state)
      WARMUP: begin
        if (cnt == CNT_W'(DELAY_CYCLES)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      IDLE, CAPTURE: begin
        if (state == CAPTURE || (trigger && enable)) begin
          push_req  = 1'b1;
          push_last = (cnt == CNT_W'(WIN_LEN - 1));
          if (push_last) begin
            state_next = HOLDOFF;
            cnt_next   = '0;
          end else begin
            state_next = CAPTURE;
            cnt_next   = cnt + CNT_W'(1);
          end
        end
      end
      HOLDOFF: begin
        if (cnt == CNT_W'(HOLDOFF_CYCLES - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = WARMUP;
        cnt_next   = '0;
      end
    endcase
  end

  // FIFO control and next head selection (pushed sample bypasses into an empty FIFO)
  always_comb begin
    pop             = out_valid && out_ready;
    full            = (count == FCNT_W'(FIFO_DEPTH));
    push_acc        = push_req && (!full || pop);
    drop            = push_req && !push_acc;
    count_after_pop = count - FCNT_W'(pop);
    count_next      = count_after_pop + FCNT_W'(push_acc);
    rd_next         = rd_ptr + PTR_W'(pop);
    head_data       = out_data;
    head_last       = 1'b0;
    if (count_after_pop != '0) begin
      head_data = mem[rd_next];
      head_last = mem_last[rd_next];
    end else if (push_acc) begin
      head_data = sr_dout;
      head_last = push_last;
    end
  end

  // FIFO storage; a dropped last sample marks the newest stored entry as last
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr]      <= sr_dout;
      mem_last[wr_ptr] <= push_last;
    end else if (drop && push_last) begin
      mem_last[wr_ptr - PTR_W'(1)] <= 1'b1;
    end
  end

  // FIFO pointers, registered outputs and overflow counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      busy         <= 1'b1;
      overflow_cnt <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      out_data  <= head_data;
      out_last  <= head_last;
      busy      <= (state_next != IDLE) || (count_next != '0);
      if (drop && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_delay_trigger_ctrl.sv
// Directed bench for delay_trigger_ctrl with DELAY=4, POST=3, FIFO_DEPTH=4,
// HOLDOFF=2 (window of 8 samples); sr_dout advances by one every cycle.
module tb_delay_trigger_ctrl;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          trigger = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] sr_dout = '0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          busy;
  logic [7:0]    overflow_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  delay_trigger_ctrl #(
    .DATA_WIDTH    (DW),
    .DELAY_CYCLES  (4),
    .POST_CYCLES   (3),
    .FIFO_DEPTH    (4),
    .HOLDOFF_CYCLES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .trigger     (trigger),
    .sr_dout     (sr_dout),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .overflow_cnt(overflow_cnt)
  );

  // One clock: wait for the edge, settle, then advance the sample counter
  task automatic step();
    @(posedge clk);
    #1;
    sr_dout = sr_dout + 16'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %b want 0", out_last); end
    tests++; if (out_data !== 16'd0) begin fails++; $display("FAIL reset_data: got %0d want 0", out_data); end
    tests++; if (overflow_cnt !== 8'd0) begin fails++; $display("FAIL reset_ovf: got %0d want 0", overflow_cnt); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", busy); end
    step();
    step();
  endtask

  task automatic test_warmup();
    rst = 1'b1;
    trigger = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL warmup_valid[%0d]: got %b want 0", i, out_valid); end
    end
    trigger = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL warmup_idle_valid: got %b want 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL warmup_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_window_ready();
    out_ready = 1'b1;
    enable = 1'b1;
    sr_dout = 16'd10;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    enable = 1'b0;  // must not abort the running window
    for (int k = 0; k < 8; k++) begin
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL win_valid[%0d]: got %b want 1", k, out_valid); end
      tests++; if (out_data !== 16'(10 + k)) begin fails++; $display("FAIL win_data[%0d]: got %0d want %0d", k, out_data, 10 + k); end
      tests++; if (out_last !== (k == 7)) begin fails++; $display("FAIL win_last[%0d]: got %b want %b", k, out_last, (k == 7)); end
      step();
    end
    enable = 1'b1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL win_drained_valid: got %b want 0", out_valid); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL win_holdoff_busy: got %b want 1", busy); end
    step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL win_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    sr_dout = 16'd10;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tests++; if (out_data !== 16'd10 || out_valid !== 1'b1) begin fails++; $display("FAIL ovf_stall[%0d]: got data %0d valid %b want 10/1", k, out_data, out_valid); end
      step();
    end
    tests++; if (overflow_cnt !== 8'd4) begin fails++; $display("FAIL ovf_count: got %0d want 4", overflow_cnt); end
    step();
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ovf_drain_valid[%0d]: got %b want 1", i, out_valid); end
      tests++; if (out_data !== 16'(10 + i)) begin fails++; $display("FAIL ovf_drain_data[%0d]: got %0d want %0d", i, out_data, 10 + i); end
      tests++; if (out_last !== (i == 3)) begin fails++; $display("FAIL ovf_drain_last[%0d]: got %b want %b", i, out_last, (i == 3)); end
      step();
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty: got %b want 0", out_valid); end
    tests++; if (overflow_cnt !== 8'd4) begin fails++; $display("FAIL ovf_hold: got %0d want 4", overflow_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ovf_busy: got %b want 0", busy); end
  endtask

  task automatic test_retrigger();
    out_ready = 1'b1;
    sr_dout = 16'd10;
    trigger = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      tests++; if (out_data !== 16'(10 + k)) begin fails++; $display("FAIL retrig_data[%0d]: got %0d want %0d", k, out_data, 10 + k); end
      step();
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL retrig_hold0: got %b want 0", out_valid); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL retrig_hold1: got %b want 0", out_valid); end
    step();
    trigger = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_data !== 16'd20) begin fails++; $display("FAIL retrig_start: got valid %b data %0d want 1/20", out_valid, out_data); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL retrig_start_last: got %b want 0", out_last); end
    for (int i = 0; i < 10; i++) step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL retrig_busy: got %b want 0", busy); end
    tests++; if (overflow_cnt !== 8'd4) begin fails++; $display("FAIL retrig_ovf: got %0d want 4", overflow_cnt); end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    sr_dout = 16'd30;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    step();
    step();
    tests++; if (out_data !== 16'd30) begin fails++; $display("FAIL full_head: got %0d want 30", out_data); end
    out_ready = 1'b1;
    step();
    tests++; if (out_data !== 16'd31) begin fails++; $display("FAIL full_pop_data: got %0d want 31", out_data); end
    tests++; if (overflow_cnt !== 8'd4) begin fails++; $display("FAIL full_pop_ovf: got %0d want 4", overflow_cnt); end
    step();
    step();
    step();
    tests++; if (out_data !== 16'd34) begin fails++; $display("FAIL full_steady_data: got %0d want 34", out_data); end
    tests++; if (overflow_cnt !== 8'd4) begin fails++; $display("FAIL full_steady_ovf: got %0d want 4", overflow_cnt); end
    for (int i = 1; i < 4; i++) begin
      step();
      tests++; if (out_data !== 16'(34 + i)) begin fails++; $display("FAIL full_drain_data[%0d]: got %0d want %0d", i, out_data, 34 + i); end
      tests++; if (out_last !== (i == 3)) begin fails++; $display("FAIL full_drain_last[%0d]: got %b want %b", i, out_last, (i == 3)); end
    end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_empty: got %b want 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] v;
    out_ready = 1'b0;
    sr_dout = 16'd40;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    tests++; if (overflow_cnt !== 8'd0) begin fails++; $display("FAIL rmid_ovf: got %0d want 0", overflow_cnt); end
    tests++; if (out_data !== 16'd0) begin fails++; $display("FAIL rmid_data: got %0d want 0", out_data); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rmid_busy: got %b want 1", busy); end
    step();
    step();
    rst = 1'b1;
    trigger = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_warmup[%0d]: got %b want 0", i, out_valid); end
    end
    v = sr_dout;
    step();
    trigger = 1'b0;
    out_ready = 1'b1;
    tests++; if (out_valid !== 1'b1 || out_data !== v) begin fails++; $display("FAIL rmid_accept: got valid %b data %0d want 1/%0d", out_valid, out_data, v); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL rmid_accept_last: got %b want 0", out_last); end
    for (int i = 0; i < 12; i++) step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_done_busy: got %b want 0", busy); end
    tests++; if (overflow_cnt !== 8'd0) begin fails++; $display("FAIL rmid_done_ovf: got %0d want 0", overflow_cnt); end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_window_ready();
    test_overflow();
    test_retrigger();
    test_full_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/delay_trigger_ctrl.md
DELAY_TRIGGER_CTRL -- requirements
Module: delay_trigger_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DBG_TIMESTAMP_WIDTH+32+16; width of one trace sample.
REQ-002 SHALL have parameter DELAY_CYCLES, default `DBG_TRIGGER_DELAY; pre-trigger depth of the attached delay shift register.
REQ-003 SHALL have parameter POST_CYCLES, default 16; samples captured after the trigger sample.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4; output buffer entries (power of two, >=2).
REQ-005 SHALL have parameter HOLDOFF_CYCLES, default 4; dead time after a window (>=1).
REQ-006 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port enable  input  1  arms trigger acceptance.
REQ-009 SHALL have port trigger  input  1  trigger request, level sampled each cycle.
REQ-010 SHALL have port sr_dout  input  DATA_WIDTH  delayed sample from the shift register, new value every cycle.
REQ-011 SHALL have ports out_data  output  DATA_WIDTH, out_last  output  1 and out_valid  output  1; FIFO head, last-of-window flag, head valid.
REQ-012 SHALL have port out_ready  input  1  consumer accept.
REQ-013 SHALL have port busy  output  1  state!=IDLE or FIFO non-empty.
REQ-014 SHALL have port overflow_cnt  output  8  saturating count of dropped samples.

Function
REQ-015 SHALL implement states WARMUP, IDLE, CAPTURE, HOLDOFF.
REQ-016 WARMUP SHALL last exactly DELAY_CYCLES+1 cycles after reset release and then go to IDLE; trigger ignored.
REQ-017 IDLE: trigger=1 and enable=1 SHALL push the current sr_dout as sample 0 and enter CAPTURE.
REQ-018 Window length SHALL be W=DELAY_CYCLES+1+POST_CYCLES samples, one per consecutive cycle, sample W-1 tagged last.
REQ-019 After pushing sample W-1, SHALL enter HOLDOFF for exactly HOLDOFF_CYCLES cycles, then IDLE.
REQ-020 trigger SHALL be ignored in WARMUP, CAPTURE and HOLDOFF; deasserting enable SHALL NOT abort a running window.
REQ-021 Push SHALL be accepted when FIFO not full, or when full and a pop occurs in the same cycle.
REQ-022 Otherwise the sample SHALL be dropped and overflow_cnt incremented, saturating at 255.
REQ-023 If a dropped sample is the last sample, the newest (tail) FIFO entry SHALL get out_last=1.
REQ-024 Pop SHALL occur when out_valid=1 and out_ready=1; out_valid SHALL equal FIFO non-empty, out_data/out_last the head, registered, no combinational path from sr_dout.
REQ-025 out_data/out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 Sample pushed at edge N SHALL be visible at out_valid no later than edge N+1 when FIFO was empty.
REQ-027 overflow_cnt SHALL clear only by reset.

Reset
REQ-028 rst=0 SHALL immediately force state WARMUP, FIFO empty, out_valid=0, out_last=0, out_data=0, overflow_cnt=0, busy=1 (WARMUP).
REQ-029 Reset asserted mid-window SHALL discard buffered samples; no partial window after release.
REQ-030 Reset deassertion SHALL be honoured on the next rising clk; WARMUP count starts there.

Verification (DELAY_CYCLES=4, POST_CYCLES=3, FIFO_DEPTH=4, HOLDOFF_CYCLES=2, W=8; sr_dout = cycle counter)
REQ-031 Trigger=1, enable=1 for the first 5 cycles after reset release -> no capture, out_valid stays 0.
REQ-032 out_ready=1, trigger pulse when sr_dout=10 -> out_data 10..17 on consecutive cycles, out_last only on 17, busy low after holdoff and drain.
REQ-033 out_ready=0 throughout window from sr_dout=10 -> FIFO holds 10,11,12,13; 13 has out_last=1; overflow_cnt=4; then out_ready=1 drains 4 entries.
REQ-034 Trigger held high from window start -> ignored during 8 CAPTURE and 2 HOLDOFF cycles, new window starts in first IDLE cycle, sample 0 = sr_dout 20 (window start 10).
REQ-035 FIFO full, out_ready=1 same cycle as push -> no drop, overflow_cnt unchanged.
REQ-036 rst=0 at sample 3 of a window -> out_valid=0 and overflow_cnt=0 asynchronously; after release 5 WARMUP cycles before any trigger accepted.
